town_accumulator: RTL and testbench

Receive-side endpoint of the visitor stream. Holds up to RESIDENTS resident bodies, loaded by the HPS. For every visitor (x, y, mass, index) presented by the visitor center, it accumulates a fixed-point force contribution onto each resident, then requests the next visitor with a one-cycle `next` pulse. It sits between the visitor center and the HPS result readback, one instance per town.

---
 rtl/town_pkg.sv | 27 ++
 rtl/town_kernel.sv | 55 +++++
 rtl/town_accumulator.sv | 222 ++++++++++++++++++++++
 tb/tb_town_accumulator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/town_pkg.sv
// town_pkg: shared types and helpers for the town accumulator.
// Defines the pass state machine encoding and the 64->32 saturate.
package town_pkg;

  localparam int FRAC_BITS_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_CAPTURE,
    S_ITER,
    S_DONE
  } state_e;

  function automatic logic [31:0] sat32(
    input logic signed [63:0] v
  );
    if (v > 64'sh0000_0000_7FFF_FFFF)
      return 32'h7FFF_FFFF;
    else if (v < -64'sh0000_0000_8000_0000)
      return 32'h8000_0000;
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/town_kernel.sv
// town_kernel: one registered stage, cx/cy = (mass * (v - r)) >>> FRAC_BITS.
// TOWN_SATURATE_EN clamps the result instead of wrapping.
module town_kernel
  import town_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [31:0] vx_i,
  input  logic [31:0] vy_i,
  input  logic [31:0] mass_i,
  input  logic [31:0] rx_i,
  input  logic [31:0] ry_i,
  output logic        valid_o,
  output logic [31:0] cx_o,
  output logic [31:0] cy_o
);

  function automatic logic [31:0] scale(
    input logic [31:0] m,
    input logic [31:0] d
  );
    logic signed [63:0] p;
    p = $signed({{32{m[31]}}, m})
      * $signed({{32{d[31]}}, d});
`ifdef TOWN_SATURATE_EN
    return sat32(p >>> FRAC_BITS);
`else
    return 32'(p >>> FRAC_BITS);
`endif
  endfunction

  logic [31:0] dx, dy;
  logic [31:0] cx_d, cy_d;

  assign dx   = vx_i - rx_i;
  assign dy   = vy_i - ry_i;
  assign cx_d = scale(mass_i, dx);
  assign cy_d = scale(mass_i, dy);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o <= 1'b0;
      cx_o    <= '0;
      cy_o    <= '0;
    end else begin
      valid_o <= valid_i;
      cx_o    <= cx_d;
      cy_o    <= cy_d;
    end
  end

endmodule

// File: rtl/town_accumulator.sv
// town_accumulator: per-town force accumulator fed by the visitor stream.
// Define TOWN_SATURATE_EN for saturating kernel and accumulator arithmetic.
module town_accumulator
  import town_pkg::*;
#(
  parameter int RESIDENTS = 16,
  parameter int RES_ADDR  = 4,
  parameter int VADDR     = 12,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hps_res_we,
  input  logic [RES_ADDR-1:0] hps_res_index,
  input  logic [31:0]         hps_res_x,
  input  logic [31:0]         hps_res_y,
  input  logic [RES_ADDR:0]   num_residents,
  input  logic                start,
  input  logic [31:0]         visitor_x_pos,
  input  logic [31:0]         visitor_y_pos,
  input  logic [31:0]         visitor_mass,
  input  logic [VADDR-1:0]    visitor_index,
  input  logic                last_visitor,
  output logic                next,
  output logic                busy,
  output logic                done,
  input  logic [RES_ADDR-1:0] rd_index,
  output logic [31:0]         rd_acc_x,
  output logic [31:0]         rd_acc_y
);

  localparam int KW = RES_ADDR + 2;

  function automatic logic [31:0] acc_add(
    input logic [31:0] a,
    input logic [31:0] c
  );
`ifdef TOWN_SATURATE_EN
    logic signed [63:0] s;
    s = $signed({{32{a[31]}}, a})
      + $signed({{32{c[31]}}, c});
    return sat32(s);
`else
    return a + c;
`endif
  endfunction

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [KW-1:0]     k_last;
  logic [RES_ADDR:0] n_q;
  logic [1:0]        set_q, set_d;
  logic              next_q, next_d;
  logic              last_q;
  logic              cap, clr, busy_w, we_ok;

  logic [31:0]       vx_q, vy_q, vm_q;
  logic [VADDR-1:0]  vidx_unused_q;

  logic [31:0]       mem_x [RESIDENTS];
  logic [31:0]       mem_y [RESIDENTS];
  logic [31:0]       rx_q, ry_q;

  logic              v1_d, v1_q;
  logic [RES_ADDR-1:0] a1_q, a2_q;
  logic              kv;
  logic [31:0]       cx, cy;

  logic [31:0]       acc_x [RESIDENTS];
  logic [31:0]       acc_y [RESIDENTS];
  logic [31:0]       rd_x_q, rd_y_q;

  assign busy_w = (state_q == S_CLEAR)
               || (state_q == S_SETTLE)
               || (state_q == S_CAPTURE)
               || (state_q == S_ITER);
  assign we_ok  = hps_res_we && !busy_w;
  assign k_last = {1'b0, n_q} + KW'(1);

  assign next     = next_q;
  assign busy     = busy_w;
  assign done     = (state_q == S_DONE);
  assign rd_acc_x = rd_x_q;
  assign rd_acc_y = rd_y_q;

  // SETTLE runs one extra cycle after ITER: that cycle carries `next`.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    set_d   = set_q;
    next_d  = 1'b0;
    cap     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr     = 1'b1;
        set_d   = 2'd1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (set_q == 2'd0) state_d = S_CAPTURE;
        else set_d = set_q - 2'd1;
      end
      S_CAPTURE: begin
        cap     = 1'b1;
        k_d     = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        k_d = k_q + KW'(1);
        if (k_q == k_last) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETTLE;
            set_d   = 2'd2;
            next_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign v1_d = (state_q == S_ITER) && (k_q < {1'b0, n_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      set_q   <= '0;
      next_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      set_q   <= set_d;
      next_q  <= next_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vx_q          <= '0;
      vy_q          <= '0;
      vm_q          <= '0;
      vidx_unused_q <= '0;
      last_q        <= 1'b0;
      n_q           <= '0;
    end else if (cap) begin
      vx_q          <= visitor_x_pos;
      vy_q          <= visitor_y_pos;
      vm_q          <= visitor_mass;
      vidx_unused_q <= visitor_index;
      last_q        <= last_visitor;
      n_q           <= num_residents;
    end
  end

  // Resident store: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (we_ok) begin
      mem_x[hps_res_index] <= hps_res_x;
      mem_y[hps_res_index] <= hps_res_y;
    end
    rx_q <= mem_x[k_q[RES_ADDR-1:0]];
    ry_q <= mem_y[k_q[RES_ADDR-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      a2_q <= '0;
    end else begin
      v1_q <= v1_d;
      a1_q <= k_q[RES_ADDR-1:0];
      a2_q <= a1_q;
    end
  end

  town_kernel #(
    .FRAC_BITS (FRAC_BITS)
  ) u_kernel (
    .clk     (clk),
    .reset   (reset),
    .valid_i (v1_q),
    .vx_i    (vx_q),
    .vy_i    (vy_q),
    .mass_i  (vm_q),
    .rx_i    (rx_q),
    .ry_i    (ry_q),
    .valid_o (kv),
    .cx_o    (cx),
    .cy_o    (cy)
  );

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < RESIDENTS; i++) begin
        acc_x[i] <= '0;
        acc_y[i] <= '0;
      end
    end else if (kv) begin
      acc_x[a2_q] <= acc_add(acc_x[a2_q], cx);
      acc_y[a2_q] <= acc_add(acc_y[a2_q], cy);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_x_q <= '0;
      rd_y_q <= '0;
    end else begin
      rd_x_q <= acc_x[rd_index];
      rd_y_q <= acc_y[rd_index];
    end
  end

endmodule

// File: tb/tb_town_accumulator.sv
// tb_town_accumulator: directed + randomized passes against a sum-of-forces model.
// Visitor center behaviour is emulated inline while each pass runs.
module tb_town_accumulator;

  localparam int RES = 16;
  localparam int RA  = 4;
  localparam int VA  = 12;
  localparam int FB  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          hps_res_we;
  logic [RA-1:0] hps_res_index;
  logic [31:0]   hps_res_x, hps_res_y;
  logic [RA:0]   num_residents;
  logic          start;
  logic [31:0]   visitor_x_pos, visitor_y_pos, visitor_mass;
  logic [VA-1:0] visitor_index;
  logic          last_visitor;
  logic          next, busy, done;
  logic [RA-1:0] rd_index;
  logic [31:0]   rd_acc_x, rd_acc_y;

  always #5 clk = ~clk;

  town_accumulator #(
    .RESIDENTS (RES),
    .RES_ADDR  (RA),
    .VADDR     (VA),
    .FRAC_BITS (FB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hps_res_we    (hps_res_we),
    .hps_res_index (hps_res_index),
    .hps_res_x     (hps_res_x),
    .hps_res_y     (hps_res_y),
    .num_residents (num_residents),
    .start         (start),
    .visitor_x_pos (visitor_x_pos),
    .visitor_y_pos (visitor_y_pos),
    .visitor_mass  (visitor_mass),
    .visitor_index (visitor_index),
    .last_visitor  (last_visitor),
    .next          (next),
    .busy          (busy),
    .done          (done),
    .rd_index      (rd_index),
    .rd_acc_x      (rd_acc_x),
    .rd_acc_y      (rd_acc_y)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] res_x [RES];
  logic [31:0] res_y [RES];
  logic [31:0] vx [8];
  logic [31:0] vy [8];
  logic [31:0] vm [8];
  logic [31:0] ex [RES];
  logic [31:0] ey [RES];

  function automatic logic [31:0] fit(input longint s);
`ifdef TOWN_SATURATE_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return 32'(s);
  endfunction

  function automatic logic [31:0] contrib(
    input logic [31:0] m, input logic [31:0] v, input logic [31:0] r
  );
    logic [31:0] d;
    longint p;
    d = v - r;
    p = longint'(signed'(m)) * longint'(signed'(d));
    return fit(p >>> FB);
  endfunction

  function automatic logic [31:0] accum(input logic [31:0] a, input logic [31:0] c);
    return fit(longint'(signed'(a)) + longint'(signed'(c)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_model(input int n, input int nv);
    for (int r = 0; r < RES; r++) begin
      ex[r] = '0;
      ey[r] = '0;
    end
    for (int v = 0; v < nv; v++)
      for (int r = 0; r < n; r++) begin
        ex[r] = accum(ex[r], contrib(vm[v], vx[v], res_x[r]));
        ey[r] = accum(ey[r], contrib(vm[v], vy[v], res_y[r]));
      end
  endtask

  task automatic wr_res(input int i, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    hps_res_we    = 1'b1;
    hps_res_index = RA'(i);
    hps_res_x     = x;
    hps_res_y     = y;
    res_x[i]      = x;
    res_y[i]      = y;
    @(negedge clk);
    hps_res_we    = 1'b0;
  endtask

  task automatic drive_vis(input int i, input int nv);
    int j;
    j = (i < 8) ? i : 7;
    visitor_x_pos = vx[j];
    visitor_y_pos = vy[j];
    visitor_mass  = vm[j];
    visitor_index = VA'(i);
    last_visitor  = (i >= nv - 1);
  endtask

  task automatic rd_chk(input string tag, input int i,
                        input logic [31:0] ex_x, input logic [31:0] ex_y);
    rd_index = RA'(i);
    @(negedge clk);
    chk($sformatf("%s acc_x[%0d]", tag, i), rd_acc_x, ex_x);
    chk($sformatf("%s acc_y[%0d]", tag, i), rd_acc_y, ex_y);
  endtask

  task automatic run_pass(input string tag, input int n, input int nv, input bit abuse);
    int k, pulses, exp_k;
    bit fin;
    build_model(n, nv);
    num_residents = (RA+1)'(n);
    drive_vis(0, nv);
    @(negedge clk);
    start  = 1'b1;
    pulses = 0;
    fin    = 1'b0;
    k      = 0;
    while (!fin && k < 2000) begin
      @(negedge clk);
      k++;
      start      = 1'b0;
      hps_res_we = 1'b0;
      if (k == 1) chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
      if (abuse && k == 6) begin
        start         = 1'b1;
        hps_res_we    = 1'b1;
        hps_res_index = '0;
        hps_res_x     = 32'hDEAD_BEEF;
        hps_res_y     = 32'h1234_5678;
      end
      if (next === 1'b1) begin
        exp_k = 4 + (pulses + 1) * (n + 3) + 3 * pulses;
        chk($sformatf("%s next_cycle[%0d]", tag, pulses), 32'(k), 32'(exp_k));
        pulses++;
        drive_vis(pulses, nv);
      end
      if (done === 1'b1) begin
        fin = 1'b1;
        exp_k = 4 + nv * (n + 3) + 3 * (nv - 1);
        chk({tag, " done_cycle"}, 32'(k), 32'(exp_k));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      end
    end
    chk({tag, " done_seen"}, 32'(fin), 32'd1);
    chk({tag, " next_pulses"}, 32'(pulses), 32'(nv - 1));
    for (int r = 0; r < RES; r++)
      rd_chk(tag, r, ex[r], ey[r]);
  endtask

  initial begin
    int n, nv;
    reset         = 1'b1;
    hps_res_we    = 1'b0;
    hps_res_index = '0;
    hps_res_x     = '0;
    hps_res_y     = '0;
    num_residents = '0;
    start         = 1'b0;
    rd_index      = '0;
    for (int i = 0; i < 8; i++) begin
      vx[i] = '0;
      vy[i] = '0;
      vm[i] = '0;
    end
    drive_vis(0, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset next", 32'(next), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rd_acc_x", rd_acc_x, 32'd0);
    chk("reset rd_acc_y", rd_acc_y, 32'd0);

    for (int i = 0; i < RES; i++) wr_res(i, '0, '0);

    // Two residents, one visitor
    wr_res(0, 32'h0, 32'h0);
    wr_res(1, 32'h1_0000, 32'h0);
    vx[0] = 32'h2_0000; vy[0] = 32'h0; vm[0] = 32'h1_0000;
    run_pass("A", 2, 1, 1'b0);
    rd_chk("A_const", 0, 32'h2_0000, 32'h0);
    rd_chk("A_const", 1, 32'h1_0000, 32'h0);

    // Three visitors over four residents
    for (int i = 0; i < 4; i++) wr_res(i, $urandom, $urandom);
    for (int v = 0; v < 3; v++) begin
      vx[v] = $urandom; vy[v] = $urandom; vm[v] = $urandom;
    end
    run_pass("B", 4, 3, 1'b0);

    // Negative contribution
    wr_res(0, 32'h3_0000, 32'h0);
    vx[0] = 32'h0; vy[0] = 32'h0; vm[0] = 32'h8000;
    run_pass("C", 1, 1, 1'b0);
    rd_chk("C_const", 0, 32'hFFFE_8000, 32'h0);

    // Kernel overflow
    wr_res(0, 32'h0, 32'h0);
    vx[0] = 32'h7FFF_0000; vy[0] = 32'h0; vm[0] = 32'h7FFF_0000;
    run_pass("D", 1, 1, 1'b0);
`ifdef TOWN_SATURATE_EN
    rd_chk("D_const", 0, 32'h7FFF_FFFF, 32'h0);
`else
    rd_chk("D_const", 0, 32'h0001_0000, 32'h0);
`endif

    // Reset in the middle of ITER, then a clean rerun
    wr_res(0, 32'h0, 32'h0);
    wr_res(1, 32'h1_0000, 32'h0);
    vx[0] = 32'h2_0000; vy[0] = 32'h0; vm[0] = 32'h1_0000;
    num_residents = 5'd2;
    drive_vis(0, 1);
    rd_index = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("E busy", 32'(busy), 32'd0);
    chk("E next", 32'(next), 32'd0);
    chk("E done", 32'(done), 32'd0);
    chk("E rd_acc_x", rd_acc_x, 32'd0);
    chk("E rd_acc_y", rd_acc_y, 32'd0);
    reset = 1'b0;
    run_pass("E_rerun", 2, 1, 1'b0);

    // start and resident write while busy must be ignored
    for (int i = 0; i < 8; i++) wr_res(i, $urandom, $urandom);
    for (int v = 0; v < 3; v++) begin
      vx[v] = $urandom; vy[v] = $urandom; vm[v] = $urandom;
    end
    run_pass("F", 8, 3, 1'b1);
    run_pass("F_again", 8, 1, 1'b0);

    // Randomized passes, including empty and full towns
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < RES; i++) wr_res(i, $urandom, $urandom);
      nv = int'($urandom_range(1, 4));
      if (p == 0) n = 0;
      else if (p == 1) n = RES;
      else n = int'($urandom_range(0, RES));
      for (int v = 0; v < nv; v++) begin
        vx[v] = $urandom; vy[v] = $urandom;
        vm[v] = (p[0]) ? $urandom : {16'h0, 16'($urandom)};
      end
      run_pass($sformatf("G%0d", p), n, nv, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
